// File: rtl/qrng_pkg.sv
// Shared types and constants for the random word generator.
package qrng_pkg;

  typedef enum logic [1:0] {
    MODE_CNT  = 2'd0,
    MODE_LFSR = 2'd1,
    MODE_ENT  = 2'd2
  } mode_e;

  localparam logic [3:0]  TAPS_W4  = 4'h9;
  localparam logic [7:0]  TAPS_W8  = 8'hB8;
  localparam logic [15:0] TAPS_W16 = 16'hB400;
  localparam logic [31:0] TAPS_W32 = 32'h8020_0003;

  // Maximal-length Galois masks for the common widths; others fall back to a simple mask.
  function automatic logic [31:0] default_taps(input int unsigned w);
    logic [31:0] t;
    case (w)
      4:       t = 32'(TAPS_W4);
      8:       t = 32'(TAPS_W8);
      16:      t = 32'(TAPS_W16);
      32:      t = TAPS_W32;
      default: t = 32'h0000_0003;
    endcase
    return t;
  endfunction

endpackage

// File: rtl/qrng_word_gen_state_step.sv
// Combinational next-state function: counter, Galois LFSR, or LFSR with entropy mixed in.
module qrng_state_step
  import qrng_pkg::*;
#(
  parameter int unsigned      WIDTH = 8,
  parameter logic [WIDTH-1:0] TAPS  = WIDTH'(8'hB8),
  parameter logic [WIDTH-1:0] SEED  = WIDTH'(1)
) (
  input  logic [WIDTH-1:0] s_i,
  input  logic [1:0]       mode_i,
  input  logic             ent_i,
  output logic [WIDTH-1:0] next_c
);

  localparam logic [WIDTH-1:0] RECOVER = SEED | WIDTH'(1);

  always_comb begin
    next_c = s_i + WIDTH'(1);
    if (mode_i != MODE_CNT) begin
      next_c = (s_i >> 1) ^ (s_i[0] ? TAPS : '0);
      if (mode_i == MODE_ENT) begin
        next_c[0] = next_c[0] ^ ent_i;
      end
      // The all-zero state is a fixed point of the LFSR; kick it back out.
      if (next_c == '0) begin
        next_c = RECOVER;
      end
    end
  end

endmodule

// File: rtl/qrng_word_gen.sv
// Random state generator with serial bit output and WIDTH-bit word assembly on valid/ready.
module qrng_word_gen
  import qrng_pkg::*;
#(
  parameter int unsigned      WIDTH = 8,
  parameter logic [WIDTH-1:0] TAPS  = WIDTH'(default_taps(WIDTH)),
  parameter logic [WIDTH-1:0] SEED  = WIDTH'(1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [1:0]       mode,
  input  logic             seed_load,
  input  logic [WIDTH-1:0] seed_in,
  input  logic             ent_in,
  output logic             bit_out,
  output logic [WIDTH-1:0] word_out,
  output logic             word_valid,
  input  logic             word_ready,
  output logic             overflow,
  input  logic             ovf_clr
);

  localparam int unsigned      CW      = $clog2(WIDTH);
  localparam logic [WIDTH-1:0] SEED_NZ = (SEED == '0) ? WIDTH'(1) : SEED;
  localparam logic [CW-1:0]    LAST    = CW'(WIDTH - 1);

  logic [WIDTH-1:0] state_q, state_d, step_c;
  logic [WIDTH-2:0] acc_q, acc_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] word_q, word_d, word_c;
  logic             valid_q, valid_d;
  logic             ovf_q, ovf_d;
  logic             bit_q, bit_d;
  logic             complete_c;

  qrng_state_step #(
    .WIDTH (WIDTH),
    .TAPS  (TAPS),
    .SEED  (SEED_NZ)
  ) u_step (
    .s_i    (state_q),
    .mode_i (mode),
    .ent_i  (ent_in),
    .next_c (step_c)
  );

  assign word_c = {acc_q, state_q[0]};

  // Generator step, word assembly, handshake and overflow tracking.
  always_comb begin
    state_d    = state_q;
    acc_d      = acc_q;
    cnt_d      = cnt_q;
    bit_d      = bit_q;
    word_d     = word_q;
    valid_d    = valid_q;
    ovf_d      = ovf_q;
    complete_c = 1'b0;

    if (seed_load) begin
      state_d = (seed_in == '0 && mode != MODE_CNT) ? WIDTH'(1) : seed_in;
      acc_d   = '0;
      cnt_d   = '0;
    end else if (en) begin
      state_d = step_c;
      acc_d   = word_c[WIDTH-2:0];
      bit_d   = state_q[0];
      if (cnt_q == LAST) begin
        cnt_d      = '0;
        complete_c = 1'b1;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end

    if (valid_q && word_ready) begin
      valid_d = 1'b0;
    end
    if (ovf_clr) begin
      ovf_d = 1'b0;
    end
    // A finished word lands only if the output slot is free or emptying now.
    if (complete_c) begin
      if (!valid_q || word_ready) begin
        word_d  = word_c;
        valid_d = 1'b1;
      end else begin
        ovf_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= SEED_NZ;
      acc_q   <= '0;
      cnt_q   <= '0;
      bit_q   <= 1'b0;
      word_q  <= '0;
      valid_q <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      word_q  <= word_d;
      valid_q <= valid_d;
      ovf_q   <= ovf_d;
    end
  end

  assign bit_out    = bit_q;
  assign word_out   = word_q;
  assign word_valid = valid_q;
  assign overflow   = ovf_q;

endmodule
